// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the sample-RAM reader and writer: RAM geometry
// and the playback state encoding.
package ram_pkg;

    localparam int RAM_DEPTH  = 87424;
    localparam int RAM_ADDR_W = 17;
    localparam int RAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_reader_skid_fifo.sv
// skid_fifo
// Two-entry FIFO that absorbs RAM read data while the stream consumer stalls.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   flush      : synchronous empty, has priority over push/pop
//   push, pop  : write wr_data / retire the head entry
//   wr_data    : entry written on push
//   rd_data    : current head entry (meaningful only when !empty)
//   full/empty : occupancy flags
module skid_fifo #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);

endmodule

// File: rtl/ram_reader.sv
// ram_reader
// Plays back the first len words of a single-port sample RAM (registered
// read, one cycle latency) as a valid/ready stream, optionally looping.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : begin playback (IDLE only) / stop and flush
//   loop_en             : replay the buffer continuously
//   num_samples         : words to play, latched on start (clamped to DEPTH)
//   busy, done          : not-IDLE flag / one-cycle pulse on return to IDLE
//   ram_addr, ram_rd_en : RAM read port; ram_wr_en/ram_wr_data tied off
//   ram_rd_data         : data for the read issued the previous cycle
//   m_valid, m_data, m_last, m_ready : output sample stream
module ram_reader
    import ram_pkg::*;
#(
    parameter int DEPTH  = RAM_DEPTH,
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] num_samples,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    output logic              ram_wr_en,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    localparam logic [ADDR_W-1:0] DEPTH_LEN = ADDR_W'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_in;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              done_q;
    logic              done_nxt;
    logic              start_ok;
    logic              issue;
    logic              last_issue;
    logic              head_valid;
    logic              bypass;
    logic              accept;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drains;
    logic [DATA_W:0]   fifo_rd_data;

    assign len_in   = (num_samples > DEPTH_LEN) ? DEPTH_LEN : num_samples;
    // The cycle done pulses is still IDLE, but a start there is deliberately dropped.
    assign start_ok = (state == IDLE) && start && !abort && !done_q;

    // When the FIFO is empty the word arriving from the RAM is offered
    // directly; it is only written into the FIFO if the consumer does not
    // take it this cycle. This keeps first-sample latency at two cycles and
    // lets one sample per cycle flow while never having more than two words
    // (stored plus in flight) outstanding.
    assign head_valid = !fifo_empty;
    assign bypass     = !head_valid && inflight_q;
    assign m_valid    = head_valid || inflight_q;
    assign {m_last, m_data} = bypass ? {inflight_last_q, ram_rd_data} : fifo_rd_data;

    assign accept    = m_valid && m_ready;
    assign fifo_pop  = accept && head_valid;
    assign fifo_push = inflight_q && !(accept && bypass);

    // Read only while stored plus in-flight words is below two.
    assign issue      = (state == RUN) && !abort && !fifo_full && !(head_valid && inflight_q);
    assign last_issue = issue && (addr_q == (len_q - ADDR_W'(1)));

    // True when, after this edge, the FIFO will hold nothing (DRAIN has no new reads).
    assign fifo_drains = fifo_empty ? !fifo_push
                                    : (!fifo_full && fifo_pop && !fifo_push);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            done_nxt  = (state != IDLE);
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        if (len_in != '0) begin
                            state_nxt = RUN;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_issue && !loop_en) begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_drains) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            done_q          <= 1'b0;
            len_q           <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state           <= state_nxt;
            done_q          <= done_nxt;
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            if (start_ok) begin
                len_q <= len_in;
            end
            // Wrapping to 0 after the last address serves both loop and drain.
            if (abort) begin
                addr_q <= '0;
            end else if (issue) begin
                addr_q <= last_issue ? '0 : addr_q + ADDR_W'(1);
            end
        end
    end

    skid_fifo #(
        .WIDTH(DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (abort),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({inflight_last_q, ram_rd_data}),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ram_addr    = addr_q;
    assign ram_rd_en   = issue;
    assign ram_wr_en   = 1'b0;
    assign ram_wr_data = '0;
    assign busy        = (state != IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader
// Self-checking bench for ram_reader with a RAM model holding mem[i]=i
// (truncated to 16 bits). A monitor records every accepted sample and
// done pulse; scenarios compare against hand-computed expectations.
module tb_ram_reader;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              loop_en;
    logic [ADDR_W-1:0] num_samples;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic              ram_wr_en;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] ram_rd_data = '0;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    int ready_mode = 0;
    int ready_cyc  = 0;

    logic [DATA_W-1:0] got_data [$];
    logic              got_last [$];
    int done_count = 0;
    int violations = 0;
    int issued     = 0;
    int accepted   = 0;

    typedef struct {
        logic [ADDR_W-1:0] num;
        int                mode;
        int                exp_count;
    } vec_t;

    vec_t vecs [5];

    ram_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .loop_en     (loop_en),
        .num_samples (num_samples),
        .busy        (busy),
        .done        (done),
        .ram_addr    (ram_addr),
        .ram_rd_en   (ram_rd_en),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready)
    );

    always #5 clk = ~clk;

    // Registered-read RAM whose contents equal the address.
    always @(posedge clk) begin
        if (ram_rd_en) begin
            ram_rd_data <= DATA_W'(ram_addr);
        end
    end

    // Consumer ready patterns: 0 always, 1 repeating 1,0,0,1, 2 two of three, 3 never.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((ready_cyc % 4) == 0) || ((ready_cyc % 4) == 3);
            2:       m_ready = ((ready_cyc % 3) != 0);
            default: m_ready = 1'b0;
        endcase
        ready_cyc++;
    end

    // Outstanding words (stored plus in flight) equal reads issued minus samples taken.
    always @(negedge clk) begin
        if (!busy) begin
            issued   = 0;
            accepted = 0;
        end
        if (ram_rd_en && ((issued - accepted) >= 2)) begin
            violations++;
        end
        if (ram_rd_en) begin
            issued++;
        end
        if (m_valid && m_ready) begin
            accepted++;
            got_data.push_back(m_data);
            got_last.push_back(m_last);
        end
        if (done) begin
            done_count++;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] n, input logic lp);
        @(posedge clk);
        #1;
        num_samples = n;
        loop_en     = lp;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int d_base, input int limit, input string name);
        int i;
        i = 0;
        while ((done_count == d_base) && (i < limit)) begin
            @(posedge clk);
            i++;
        end
        checkOutput(name, 64'(done_count != d_base), 64'd1);
    endtask

    task automatic waitSamples(input int target, input int limit, input string name);
        int i;
        i = 0;
        while ((got_data.size() < target) && (i < limit)) begin
            @(posedge clk);
            i++;
        end
        checkOutput(name, 64'(got_data.size() >= target), 64'd1);
    endtask

    task automatic runPlayback(input logic [ADDR_W-1:0] n, input int mode, input int exp_count,
                               input string tag);
        int base;
        int d_base;
        int v_base;
        int got;
        int seq_err;
        base   = got_data.size();
        d_base = done_count;
        v_base = violations;
        ready_mode = mode;
        applyStimulus(n, 1'b0);
        waitDone(d_base, exp_count * 3 + 50, {tag, "_doneSeen"});
        repeat (3) @(posedge clk);
        got = got_data.size() - base;
        checkOutput({tag, "_count"}, 64'(got), 64'(exp_count));
        seq_err = 0;
        for (int k = 0; k < got; k++) begin
            if ((got_data[base + k] !== DATA_W'(k)) || (got_last[base + k] !== (k == exp_count - 1))) begin
                seq_err++;
            end
        end
        checkOutput({tag, "_sequence"}, 64'(seq_err), 64'd0);
        checkOutput({tag, "_donePulses"}, 64'(done_count - d_base), 64'd1);
        checkOutput({tag, "_rdRule"}, 64'(violations - v_base), 64'd0);
        if (got > 0) begin
            checkOutput({tag, "_finalSample"}, {47'd0, got_last[base + got - 1], got_data[base + got - 1]},
                        {47'd0, 1'b1, DATA_W'(exp_count - 1)});
        end
    endtask

    initial begin
        logic              rd_e;
        logic [ADDR_W-1:0] addr_e;
        logic              v_e;
        logic              last_e;
        logic [DATA_W-1:0] data_e;
        logic              done_e;
        logic              busy_e;
        int base;
        int d_base;
        int v_base;
        int got;
        int seq_err;

        vecs[0] = '{17'd8,      0, 8};
        vecs[1] = '{17'd16,     1, 16};
        vecs[2] = '{17'd1,      0, 1};
        vecs[3] = '{17'd5,      2, 5};
        vecs[4] = '{17'd100000, 0, 87424};

        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        loop_en     = 1'b0;
        num_samples = '0;

        // Outputs while held in reset.
        repeat (2) @(negedge clk);
        checkOutput("resetOutputs",
                    64'({busy, done, m_valid, m_last, ram_rd_en, ram_wr_en, ram_addr, m_data, ram_wr_data}),
                    64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Cycle-exact 8-sample playback; cycle 0 is the start cycle.
        $display("[TB] cycle-exact playback of 8 samples");
        #1;
        num_samples = 17'd8;
        start       = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            rd_e   = (c >= 1) && (c <= 8);
            addr_e = rd_e ? ADDR_W'(c - 1) : '0;
            v_e    = (c >= 2) && (c <= 9);
            last_e = (c == 9);
            data_e = v_e ? DATA_W'(c - 2) : '0;
            done_e = (c == 10);
            busy_e = (c >= 1) && (c <= 9);
            checkOutput($sformatf("cycle%0d", c),
                        64'({ram_rd_en, ram_addr, m_valid, m_valid & m_last, m_valid ? m_data : 16'h0, done, busy}),
                        64'({rd_e, addr_e, v_e, last_e, data_e, done_e, busy_e}));
            @(posedge clk);
            #1;
            start = 1'b0;
        end

        // Zero length: done next cycle, and a start during that done cycle is dropped.
        $display("[TB] zero-length start");
        repeat (2) @(posedge clk);
        base   = got_data.size();
        d_base = done_count;
        #1;
        num_samples = '0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        num_samples = 17'd4;
        @(negedge clk);
        checkOutput("zeroLenDone", 64'({done, busy}), 64'b10);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("startOnDoneIgnored", 64'({done, busy, m_valid}), 64'd0);
        repeat (6) @(posedge clk);
        checkOutput("zeroLenNoSamples", 64'(got_data.size() - base), 64'd0);
        checkOutput("zeroLenOneDone", 64'(done_count - d_base), 64'd1);

        // Table of straight playbacks.
        for (int i = 0; i < 5; i++) begin
            $display("[TB] vector %0d: num_samples=%0d ready mode %0d", i, vecs[i].num, vecs[i].mode);
            runPlayback(vecs[i].num, vecs[i].mode, vecs[i].exp_count, $sformatf("vec%0d", i));
        end

        // Loop mode: 4 samples repeated until loop_en drops after the third pass.
        $display("[TB] loop mode");
        base       = got_data.size();
        d_base     = done_count;
        v_base     = violations;
        ready_mode = 0;
        applyStimulus(17'd4, 1'b1);
        waitSamples(base + 12, 200, "loopThreePasses");
        #1;
        loop_en = 1'b0;
        waitDone(d_base, 100, "loopDoneSeen");
        repeat (3) @(posedge clk);
        got = got_data.size() - base;
        checkOutput("loopCountWholePasses", 64'(((got % 4) == 0) && (got >= 12) && (got <= 20)), 64'd1);
        seq_err = 0;
        for (int k = 0; k < got; k++) begin
            if ((got_data[base + k] !== DATA_W'(k % 4)) || (got_last[base + k] !== ((k % 4) == 3))) begin
                seq_err++;
            end
        end
        checkOutput("loopSequence", 64'(seq_err), 64'd0);
        checkOutput("loopDonePulses", 64'(done_count - d_base), 64'd1);
        checkOutput("loopRdRule", 64'(violations - v_base), 64'd0);

        // Abort after 5 samples of 20 with the consumer stalled.
        $display("[TB] abort mid-playback");
        base   = got_data.size();
        d_base = done_count;
        ready_mode = 0;
        applyStimulus(17'd20, 1'b0);
        waitSamples(base + 5, 100, "abortReachSample5");
        #1;
        ready_mode = 3;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abortNextCycle", 64'({m_valid, busy, done}), 64'b001);
        @(negedge clk);
        checkOutput("abortAfter", 64'({m_valid, busy, done}), 64'b000);
        checkOutput("abortOneDone", 64'(done_count - d_base), 64'd1);
        runPlayback(17'd3, 0, 3, "afterAbort");

        // Reset pulse after 10 samples of 50.
        $display("[TB] reset mid-playback");
        base   = got_data.size();
        d_base = done_count;
        ready_mode = 0;
        applyStimulus(17'd50, 1'b0);
        waitSamples(base + 10, 100, "resetReachSample10");
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midResetOutputs",
                    64'({busy, done, m_valid, m_last, ram_rd_en, ram_wr_en, ram_addr, m_data, ram_wr_data}),
                    64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        checkOutput("midResetNoDone", 64'(done_count - d_base), 64'd0);
        runPlayback(17'd4, 0, 4, "afterReset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_reader.md
RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 Parameter DEPTH, default 87424, number of 16-bit words in the sample RAM.
REQ-002 Parameter ADDR_W, default 17, RAM address width.
REQ-003 Parameter DATA_W, default 16, sample width.
REQ-004 Ports: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 Control and status ports:
- start  in  1  one-cycle request to begin playback; ignored unless IDLE.
- abort  in  1  stop playback and flush.
- loop_en  in  1  replay buffer continuously.
- num_samples  in  ADDR_W  words to play, sampled on start.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
REQ-006 RAM-side ports (single-port RAM, registered read, 1-cycle latency, rd_data held while rd_en low):
- ram_addr  out  ADDR_W  address.
- ram_rd_en  out  1  read strobe.
- ram_wr_en  out  1  tied to 0.
- ram_wr_data  out  DATA_W  tied to 0.
- ram_rd_data  in  DATA_W  data for the read issued the previous cycle.
REQ-007 Stream ports:
- m_valid  out  1  sample available.
- m_data  out  DATA_W  sample.
- m_last  out  1  marks the final sample of a pass.
- m_ready  in  1  consumer accepts when m_valid and m_ready are both high.

Function
REQ-008 States: IDLE, RUN, DRAIN.
- IDLE->RUN on start with length>0.
- RUN->DRAIN when the last read of the final pass is issued.
- DRAIN->IDLE when the FIFO is empty and no read is in flight.
REQ-009 Length latched as min(num_samples, DEPTH); start with num_samples=0 shall pulse done the next cycle and emit nothing.
REQ-010 Addresses issued in RUN: 0,1,...,len-1, incrementing by 1 per issued read; ram_rd_en high only on cycles a read is issued.
REQ-011 A read shall be issued only when FIFO occupancy plus in-flight reads is less than 2; no sample is ever dropped or duplicated under any m_ready pattern.
REQ-012 Captured ram_rd_data is written to the FIFO exactly one cycle after the corresponding ram_rd_en.
REQ-013 m_data/m_valid come from the FIFO head; m_valid holds and m_data is stable until accepted.
REQ-014 Throughput: with m_ready held high, one sample per cycle; first m_valid appears 2 cycles after the start cycle.
REQ-015 m_last travels with the sample read from address len-1, in every pass.
REQ-016 Loop mode:
- loop_en is sampled when address len-1 is issued; if high, the next address is 0 and the state stays RUN.
- If low, the state goes to DRAIN.
REQ-017 Abort in any state:
- next cycle: state IDLE, FIFO flushed, in-flight read discarded, m_valid low, done pulsed if the state was not IDLE.
- abort has priority over a simultaneous start.
REQ-018 A start received while busy is ignored; a start on the cycle done pulses is also ignored.

Reset
REQ-019 While rst_n is low, outputs shall be:
- state IDLE; busy, done, m_valid, m_last, ram_rd_en at 0.
- ram_addr, m_data at 0.
- FIFO empty, in-flight flag 0.
REQ-020 Reset asserted mid-playback abandons the transfer without a done pulse; the first start after rst_n rises behaves identically to the first start after power-up.

Structure
REQ-021 Package ram_pkg shall hold RAM_DEPTH=87424, RAM_ADDR_W=17, RAM_DATA_W=16 and the state enum (IDLE, RUN, DRAIN), shared with the RAM writer.
REQ-022 The 2-entry buffer shall be a sub-module skid_fifo (parameter DATA_W+1 for data plus last flag, push/pop/full/empty, synchronous flush, asynchronous active-low reset).

Verification
REQ-023 RAM preloaded mem[i]=i; num_samples=8, m_ready=1 -> m_data 0..7 on 8 consecutive cycles, m_last only with 7, done pulse after 7 is accepted.
REQ-024 num_samples=16, m_ready toggling 1,0,0,1 repeating -> exactly 0..15 in order, no gaps or duplicates, ram_rd_en never issued when the FIFO plus in-flight count is 2.
REQ-025 loop_en=1, num_samples=4 for 3 passes, then loop_en dropped -> sequence 0,1,2,3 x3 (or x4 depending on the sample point), m_last on every 3, then done.
REQ-026 num_samples=100000 -> 87424 samples, last address 87423 with m_last; num_samples=0 -> done one cycle later, m_valid never asserted.
REQ-027 abort at sample 5 of 20 with m_ready=0 -> next cycle m_valid=0, busy=0, done=1; a new start with 3 samples then yields 0,1,2.
REQ-028 rst_n pulsed low at sample 10 of 50 -> all outputs 0 during reset, no done pulse, and a subsequent start with 4 samples yields 0..3.
